// File: rtl/spi_reg_file.sv
// SPI slave in front of a 2^ADDR_W x DATA_W register file.
// SPI pins are resynchronised to clk; word 0 is mirrored on LEDsOut.
//   state   | meaning
//   ST_IDLE | cs high, waiting for a synchronised cs fall
//   ST_CMD  | shifting in RW bit + start address
//   ST_DATA | streaming data frames, write or read per RW
module spi_reg_file #(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 7,
  parameter int CPOL     = 0,
  parameter int CPHA     = 0,
  parameter int AUTO_INC = 1
) (
  input  logic              clk,
  input  logic              resetN,
  input  logic              cs,
  input  logic              sck,
  input  logic              mosi,
  output logic              miso,
  output logic [DATA_W-1:0] LEDsOut,
  output logic              busy,
  output logic              wrStrobe,
  output logic [ADDR_W-1:0] wrAddr,
  output logic [DATA_W-1:0] wrData
);
  localparam int   DEPTH    = 1 << ADDR_W;
  localparam int   RX_W     = (ADDR_W + 1 > DATA_W) ? ADDR_W + 1 : DATA_W;
  localparam int   CNT_W    = $clog2(RX_W + 1);
  localparam logic SCK_IDLE = (CPOL != 0);

  typedef enum logic [1:0] {ST_IDLE, ST_CMD, ST_DATA} state_t;

  state_t            state_q;
  logic [1:0]        cs_sync_q;
  logic [1:0]        sck_sync_q;
  logic [1:0]        mosi_sync_q;
  logic              cs_prev_q;
  logic              sck_prev_q;
  logic [CNT_W-1:0]  bit_cnt_q;
  logic [RX_W-2:0]   rx_q;
  logic [DATA_W-1:0] tx_q;
  logic              rw_q;
  logic [ADDR_W-1:0] addr_q;
  logic              wr_pend_q;
  logic [ADDR_W-1:0] pend_addr_q;
  logic [DATA_W-1:0] pend_data_q;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic              miso_q;
  logic              busy_q;
  logic              wr_strobe_q;
  logic [DATA_W-1:0] leds_q;
  logic [ADDR_W-1:0] wr_addr_q;
  logic [DATA_W-1:0] wr_data_q;

  logic              cs_s, sck_s, mosi_s;
  logic              cs_fall, cs_rise;
  logic              lead_edge, trail_edge, sample_edge, shift_edge;
  logic              cmd_done, data_done;
  logic [RX_W-1:0]   rx_d;
  logic [ADDR_W-1:0] addr_d;

  always_comb begin
    cs_s        = cs_sync_q[1];
    sck_s       = sck_sync_q[1];
    mosi_s      = mosi_sync_q[1];
    cs_fall     = cs_prev_q & ~cs_s;
    cs_rise     = ~cs_prev_q & cs_s;
    lead_edge   = (sck_s != sck_prev_q) && (sck_s != SCK_IDLE);
    trail_edge  = (sck_s != sck_prev_q) && (sck_s == SCK_IDLE);
    sample_edge = (CPHA != 0) ? trail_edge : lead_edge;
    shift_edge  = (CPHA != 0) ? lead_edge : trail_edge;
    rx_d        = {rx_q, mosi_s};
    cmd_done    = sample_edge && (state_q == ST_CMD) && (bit_cnt_q == CNT_W'(ADDR_W));
    data_done   = sample_edge && (state_q == ST_DATA) && (bit_cnt_q == CNT_W'(DATA_W - 1));
    addr_d      = (AUTO_INC != 0) ? addr_q + ADDR_W'(1) : addr_q;
  end

  always_ff @(posedge clk) begin
    if (!resetN) begin
      state_q     <= ST_IDLE;
      // cs sync starts low so a cs held low through reset never looks like a fall
      cs_sync_q   <= '0;
      cs_prev_q   <= 1'b0;
      sck_sync_q  <= {2{SCK_IDLE}};
      sck_prev_q  <= SCK_IDLE;
      mosi_sync_q <= '0;
      bit_cnt_q   <= '0;
      rx_q        <= '0;
      tx_q        <= '0;
      rw_q        <= 1'b0;
      addr_q      <= '0;
      wr_pend_q   <= 1'b0;
      pend_addr_q <= '0;
      pend_data_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      miso_q      <= 1'b0;
      busy_q      <= 1'b0;
      wr_strobe_q <= 1'b0;
      leds_q      <= '0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
    end else begin
      cs_sync_q   <= {cs_sync_q[0], cs};
      sck_sync_q  <= {sck_sync_q[0], sck};
      mosi_sync_q <= {mosi_sync_q[0], mosi};
      cs_prev_q   <= cs_s;
      sck_prev_q  <= sck_s;
      wr_strobe_q <= 1'b0;
      wr_pend_q   <= 1'b0;

      if (wr_pend_q) begin
        mem_q[pend_addr_q] <= pend_data_q;
        wr_strobe_q        <= 1'b1;
        wr_addr_q          <= pend_addr_q;
        wr_data_q          <= pend_data_q;
        if (pend_addr_q == '0) leds_q <= pend_data_q;
      end

      case (state_q)
        ST_IDLE: begin
          if (cs_fall) begin
            state_q   <= ST_CMD;
            bit_cnt_q <= '0;
            busy_q    <= 1'b1;
          end
        end
        ST_CMD: begin
          if (sample_edge) begin
            rx_q <= rx_d[RX_W-2:0];
            if (cmd_done) begin
              bit_cnt_q <= '0;
              rw_q      <= rx_d[ADDR_W];
              addr_q    <= rx_d[ADDR_W-1:0];
              tx_q      <= mem_q[rx_d[ADDR_W-1:0]];
              state_q   <= ST_DATA;
            end else begin
              bit_cnt_q <= bit_cnt_q + 1'b1;
            end
          end
        end
        ST_DATA: begin
          if (sample_edge) begin
            rx_q <= rx_d[RX_W-2:0];
            if (data_done) begin
              bit_cnt_q <= '0;
              addr_q    <= addr_d;
              if (rw_q) begin
                wr_pend_q   <= 1'b1;
                pend_addr_q <= addr_q;
                pend_data_q <= rx_d[DATA_W-1:0];
              end else begin
                tx_q <= mem_q[addr_d];
              end
            end else begin
              bit_cnt_q <= bit_cnt_q + 1'b1;
            end
          end
          if (shift_edge) begin
            miso_q <= ~rw_q & tx_q[DATA_W-1];
            tx_q   <= tx_q << 1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase

      // a frame completing in this same clk has already been queued above
      if (cs_rise) begin
        state_q   <= ST_IDLE;
        bit_cnt_q <= '0;
        miso_q    <= 1'b0;
        busy_q    <= 1'b0;
      end
    end
  end

  assign miso     = miso_q;
  assign LEDsOut  = leds_q;
  assign busy     = busy_q;
  assign wrStrobe = wr_strobe_q;
  assign wrAddr   = wr_addr_q;
  assign wrData   = wr_data_q;

endmodule

// File: tb/tb_spi_reg_file.sv
// Bench for spi_reg_file: four SPI modes plus a fixed-address instance,
// compared against a plain array model of each register file.
module tb_spi_reg_file;
  localparam int NI   = 5;
  localparam int HALF = 5;

  logic       clk = 1'b0;
  logic       resetN;
  logic       cs_w   [NI];
  logic       sck_w  [NI];
  logic       mosi_w [NI];
  logic       miso_w [NI];
  logic       busy_w [NI];
  logic       strb_w [NI];
  logic [7:0] leds_w [NI];
  logic [6:0] wa_w   [NI];
  logic [7:0] wd_w   [NI];

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    spi_reg_file #(
      .DATA_W(8), .ADDR_W(7),
      .CPOL((g < 4) ? g / 2 : 0), .CPHA((g < 4) ? g % 2 : 0),
      .AUTO_INC((g < 4) ? 1 : 0)
    ) u_dut (
      .clk(clk), .resetN(resetN), .cs(cs_w[g]), .sck(sck_w[g]), .mosi(mosi_w[g]),
      .miso(miso_w[g]), .LEDsOut(leds_w[g]), .busy(busy_w[g]), .wrStrobe(strb_w[g]),
      .wrAddr(wa_w[g]), .wrData(wd_w[g])
    );
  end

  typedef struct {
    int              inst;
    logic [7:0]      cmd;
    int              nfr;
    logic [3:0][7:0] d;
    logic [3:0][7:0] exp_rx;
    logic [3:0][6:0] exp_wa;
    logic [7:0]      exp_leds;
  } vec_t;

  vec_t       tbl [11];
  logic [7:0] mem_m [NI][128];
  int         strb_cnt [NI] = '{0, 0, 0, 0, 0};
  logic [6:0] log_a [NI][16];
  logic [7:0] log_d [NI][16];
  int         n_pass = 0;
  int         n_total = 0;

  function automatic logic cpol_of(input int i);
    return (i < 4) ? ((i / 2) != 0) : 1'b0;
  endfunction

  function automatic logic cpha_of(input int i);
    return (i < 4) ? ((i % 2) != 0) : 1'b0;
  endfunction

  function automatic logic [3:0][7:0] pk(input logic [7:0] a, b, c, e);
    return {e, c, b, a};
  endfunction

  function automatic logic [3:0][6:0] pa(input logic [6:0] a, b, c, e);
    return {e, c, b, a};
  endfunction

  always @(negedge clk) begin
    for (int i = 0; i < NI; i++) begin
      if (strb_w[i] === 1'b1) begin
        log_a[i][strb_cnt[i] % 16] = wa_w[i];
        log_d[i][strb_cnt[i] % 16] = wd_w[i];
        strb_cnt[i]++;
      end
    end
  end

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
  endtask

  task automatic spi_frame(input int i, input int nbits, input logic [31:0] tx, output logic [31:0] rx);
    logic pol, pha;
    pol = cpol_of(i);
    pha = cpha_of(i);
    rx  = '0;
    for (int b = nbits - 1; b >= 0; b--) begin
      if (!pha) begin
        mosi_w[i] = tx[b];
        wait_clk(HALF);
        rx = {rx[30:0], miso_w[i]};
        sck_w[i] = ~pol;
        wait_clk(HALF);
        sck_w[i] = pol;
      end else begin
        sck_w[i]  = ~pol;
        mosi_w[i] = tx[b];
        wait_clk(HALF);
        rx = {rx[30:0], miso_w[i]};
        sck_w[i] = pol;
        wait_clk(HALF);
      end
    end
  endtask

  task automatic spi_xfer(input int i, input logic [7:0] cmd, input int n,
                          input logic [3:0][7:0] d, output logic [3:0][7:0] rx);
    logic [31:0] r;
    rx = '0;
    cs_w[i] = 1'b0;
    wait_clk(HALF);
    spi_frame(i, 8, {24'd0, cmd}, r);
    for (int k = 0; k < n; k++) begin
      spi_frame(i, 8, {24'd0, d[k]}, r);
      rx[k] = r[7:0];
    end
    wait_clk(HALF);
    cs_w[i] = 1'b1;
    wait_clk(8);
  endtask

  // Register-file semantics: writes land at successive addresses (mod 128),
  // reads return the stored words; instance 4 never advances its address.
  function automatic void model_xfer(input int i, input logic [7:0] cmd, input int n,
                                     input logic [3:0][7:0] d,
                                     output logic [3:0][7:0] rx, output logic [3:0][6:0] wa);
    int a = int'(cmd[6:0]);
    rx = '0;
    wa = '0;
    for (int k = 0; k < n; k++) begin
      if (cmd[7]) begin
        mem_m[i][a] = d[k];
        wa[k] = 7'(a);
      end else begin
        rx[k] = mem_m[i][a];
      end
      if (i != 4) a = (a + 1) % 128;
    end
  endfunction

  task automatic run_and_check(input string tag, input int i, input logic [7:0] cmd, input int n,
                               input logic [3:0][7:0] d, input logic [3:0][7:0] exp_rx,
                               input logic [3:0][6:0] exp_wa, input logic [7:0] exp_leds);
    logic [3:0][7:0] rx;
    int c0, s;
    c0 = strb_cnt[i];
    spi_xfer(i, cmd, n, d, rx);
    for (int k = 0; k < n; k++)
      chk($sformatf("%s miso frame%0d", tag, k), {24'd0, rx[k]}, {24'd0, exp_rx[k]});
    chk($sformatf("%s strobes", tag), 32'(strb_cnt[i] - c0), cmd[7] ? 32'(n) : 32'd0);
    if (cmd[7]) begin
      for (int k = 0; k < n; k++) begin
        s = c0 + k;
        chk($sformatf("%s wrAddr%0d", tag, k), {25'd0, log_a[i][s % 16]}, {25'd0, exp_wa[k]});
        chk($sformatf("%s wrData%0d", tag, k), {24'd0, log_d[i][s % 16]}, {24'd0, d[k]});
      end
    end
    chk($sformatf("%s LEDsOut", tag), {24'd0, leds_w[i]}, {24'd0, exp_leds});
  endtask

  task automatic model_run(input string tag, input int i, input logic [7:0] cmd, input int n,
                           input logic [3:0][7:0] d);
    logic [3:0][7:0] erx;
    logic [3:0][6:0] ewa;
    model_xfer(i, cmd, n, d, erx, ewa);
    run_and_check(tag, i, cmd, n, d, erx, ewa, mem_m[i][0]);
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: got %0d checks done, expected run to complete", n_total);
    $fatal(1);
  end

  initial begin
    logic [31:0]     r;
    logic [3:0][7:0] zr, erx;
    logic [3:0][6:0] ewa;
    logic [3:0][7:0] rd;
    int              c0;

    zr = '0;
    resetN = 1'b0;
    for (int i = 0; i < NI; i++) begin
      cs_w[i]   = 1'b1;
      sck_w[i]  = cpol_of(i);
      mosi_w[i] = 1'b0;
      for (int a = 0; a < 128; a++) mem_m[i][a] = 8'h00;
    end

    tbl[0]  = '{0, 8'h80, 1, pk(8'hA5, 8'h00, 8'h00, 8'h00), zr, pa(7'h00, 7'h00, 7'h00, 7'h00), 8'hA5};
    for (int j = 0; j < 4; j++) begin
      tbl[1 + j] = '{j, 8'hFE, 3, pk(8'h11, 8'h22, 8'h33, 8'h00), zr,
                     pa(7'h7E, 7'h7F, 7'h00, 7'h00), 8'h33};
      tbl[5 + j] = '{j, 8'h7E, 3, zr, pk(8'h11, 8'h22, 8'h33, 8'h00),
                     pa(7'h00, 7'h00, 7'h00, 7'h00), 8'h33};
    end
    tbl[9]  = '{4, 8'h85, 2, pk(8'h01, 8'h02, 8'h00, 8'h00), zr, pa(7'h05, 7'h05, 7'h00, 7'h00), 8'h00};
    tbl[10] = '{4, 8'h05, 2, zr, pk(8'h02, 8'h02, 8'h00, 8'h00), pa(7'h00, 7'h00, 7'h00, 7'h00), 8'h00};

    wait_clk(4);
    for (int i = 0; i < NI; i++)
      chk($sformatf("reset outputs inst%0d", i),
          {6'd0, miso_w[i], busy_w[i], strb_w[i], leds_w[i], wa_w[i], wd_w[i]}, 32'd0);
    resetN = 1'b1;
    wait_clk(6);
    chk("idle busy after reset", {31'd0, busy_w[0]}, 32'd0);

    for (int v = 0; v < 11; v++) begin
      model_xfer(tbl[v].inst, tbl[v].cmd, tbl[v].nfr, tbl[v].d, erx, ewa);
      run_and_check($sformatf("vec%0d inst%0d", v, tbl[v].inst), tbl[v].inst, tbl[v].cmd,
                    tbl[v].nfr, tbl[v].d, tbl[v].exp_rx, tbl[v].exp_wa, tbl[v].exp_leds);
    end

    // cs rises 5 bits into a write data frame
    c0 = strb_cnt[0];
    cs_w[0] = 1'b0;
    wait_clk(HALF);
    spi_frame(0, 8, 32'h81, r);
    spi_frame(0, 5, 32'h1F, r);
    wait_clk(HALF);
    cs_w[0] = 1'b1;
    wait_clk(8);
    chk("data abort strobes", 32'(strb_cnt[0] - c0), 32'd0);
    chk("data abort busy", {31'd0, busy_w[0]}, 32'd0);
    model_run("data abort readback", 0, 8'h01, 1, zr);
    model_run("post abort write", 0, 8'h81, 1, pk(8'h5C, 8'h00, 8'h00, 8'h00));
    model_run("post abort read", 0, 8'h01, 1, zr);

    // cs rises inside the command frame
    c0 = strb_cnt[0];
    cs_w[0] = 1'b0;
    wait_clk(HALF);
    spi_frame(0, 4, 32'hF, r);
    wait_clk(HALF);
    cs_w[0] = 1'b1;
    wait_clk(8);
    chk("cmd abort strobes", 32'(strb_cnt[0] - c0), 32'd0);
    model_run("cmd abort readback", 0, 8'h7E, 2, zr);

    // one-clk reset in the middle of a write burst
    cs_w[0] = 1'b0;
    wait_clk(HALF);
    spi_frame(0, 8, 32'h80, r);
    spi_frame(0, 8, 32'h77, r);
    spi_frame(0, 3, 32'h5, r);
    chk("pre-reset LEDsOut", {24'd0, leds_w[0]}, 32'h77);
    chk("pre-reset busy", {31'd0, busy_w[0]}, 32'd1);
    resetN = 1'b0;
    wait_clk(1);
    resetN = 1'b1;
    for (int i = 0; i < NI; i++) begin
      chk($sformatf("mid-burst reset outputs inst%0d", i),
          {6'd0, miso_w[i], busy_w[i], strb_w[i], leds_w[i], wa_w[i], wd_w[i]}, 32'd0);
      for (int a = 0; a < 128; a++) mem_m[i][a] = 8'h00;
    end
    wait_clk(10);
    chk("stay idle with cs held low", {31'd0, busy_w[0]}, 32'd0);
    cs_w[0] = 1'b1;
    wait_clk(8);
    model_run("post-reset read addr0", 0, 8'h00, 1, zr);
    model_run("post-reset read 0x7E", 0, 8'h7E, 2, zr);

    for (int t = 0; t < 40; t++) begin
      int         i, n;
      logic [7:0] cmd;
      i   = $urandom_range(0, NI - 1);
      n   = $urandom_range(1, 4);
      cmd = 8'($urandom);
      // bias half the transactions toward a small window so reads hit written words
      if (t % 2 == 1) cmd[6:0] = 7'($urandom_range(0, 7));
      for (int k = 0; k < 4; k++) rd[k] = 8'($urandom);
      model_run($sformatf("rand%0d inst%0d cmd%02h", t, i, cmd), i, cmd, n, rd);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/spi_reg_file.md
SPI_REG_FILE -- requirements
Module: spi_reg_file

Interface
REQ-001 The block SHALL have parameter DATA_W, default 8, giving the data frame width in bits (range 4..32).
REQ-002 The block SHALL have parameter ADDR_W, default 7, giving the address width; memory depth is 2^ADDR_W words.
REQ-003 The block SHALL have parameter CPOL, default 0, giving the SCK idle level.
REQ-004 The block SHALL have parameter CPHA, default 0, selecting the sample edge: 0 = leading edge, 1 = trailing edge.
REQ-005 The block SHALL have parameter AUTO_INC, default 1, enabling address post-increment after each data frame.
REQ-006 clk  in  1  the single system clock; all state is updated on posedge clk.
REQ-007 resetN  in  1  synchronous, active-low reset.
REQ-008 cs  in  1  asynchronous SPI chip select, active low.
REQ-009 sck  in  1  asynchronous SPI clock.
REQ-010 mosi  in  1  asynchronous SPI data in, MSB first.
REQ-011 miso  out  1  SPI data out, MSB first; 0 while cs is high, with no tristate.
REQ-012 LEDsOut  out  DATA_W  registered copy of memory word 0.
REQ-013 busy  out  1  high while synchronised cs is low.
REQ-014 wrStrobe  out  1  one-clk pulse per completed write frame.
REQ-015 wrAddr  out  ADDR_W  address of the last write; wrData  out  DATA_W  data of the last write.

Function
REQ-016 cs, sck and mosi SHALL each pass through a 2-flop synchroniser; edges SHALL be detected on the synchronised signals only.
REQ-017 Correct operation SHALL be guaranteed for clk >= 8x sck, with each sck phase >= 4 clk.
REQ-018 A leading edge is a transition of sck away from CPOL and a trailing edge is a transition back to CPOL; the sample edge is leading if CPHA=0 and trailing if CPHA=1, and the shift edge is the other edge.
REQ-019 The FSM SHALL have states IDLE, CMD, DATA; IDLE->CMD on synchronised cs fall, CMD->DATA on command-frame completion, and any state->IDLE on synchronised cs rise.
REQ-020 The command frame SHALL be 1+ADDR_W bits: the first bit is RW (1 = write, 0 = read), followed by the start address, MSB first.
REQ-021 Each subsequent frame SHALL be DATA_W bits; a frame completes on its last sample edge.
REQ-022 The bit counter SHALL reset to 0 on cs fall and at every frame completion.
REQ-023 On write-frame completion: the memory write and wrStrobe SHALL occur 1 clk later, and wrAddr/wrData SHALL update in the same clk.
REQ-024 On a write to address 0, LEDsOut SHALL update in the same clk as the memory write.
REQ-025 For reads, the word mem[addr] SHALL be loaded into the TX shift register at command completion and at each read-frame completion, and miso SHALL present its MSB before the frame's first sample edge.
REQ-026 For CPHA=0 the first frame's MSB SHALL be driven by the first shift edge after load; for CPHA=1 it SHALL be driven by the first leading edge.
REQ-027 With AUTO_INC=1, addr SHALL increment after each data frame, read or write.
REQ-028 Address wrap: 2^ADDR_W-1 increments to 0; with AUTO_INC=0 the address SHALL stay fixed.
REQ-029 In write mode miso SHALL be 0 during data frames.
REQ-030 On cs rise mid-frame: partial bits SHALL be discarded, no write or strobe SHALL occur, and the FSM SHALL return to IDLE within 3 clk.
REQ-031 A cs rise within a command frame SHALL abort the transaction with no memory effect.
REQ-032 A cs fall while in DATA (glitch shorter than the synchroniser) SHALL be ignored; only synchronised edges count.
REQ-033 Simultaneous write completion and cs rise SHALL still commit the completed frame.

Reset
REQ-034 When resetN is low at posedge clk, the block SHALL clear state to IDLE, bit counter and addr to 0, all memory words and LEDsOut to 0, miso, busy and wrStrobe to 0, and wrAddr and wrData to 0.
REQ-035 Reset mid-transaction SHALL abort it; the block SHALL stay IDLE until a new synchronised cs fall after resetN returns high.

Verification
REQ-036 The bench SHALL cover: defaults, write cmd 0x80 (RW=1, addr 0) then data 0xA5 -> one wrStrobe, wrAddr=0, wrData=0xA5, LEDsOut=0xA5.
REQ-037 The bench SHALL cover: burst write cmd 0xFE (addr 0x7E) then 0x11, 0x22, 0x33 -> mem[0x7E]=0x11, mem[0x7F]=0x22, mem[0x00]=0x33 (wrap), LEDsOut=0x33.
REQ-038 The bench SHALL cover: read cmd 0x7E then 3 dummy frames -> miso returns 0x11, 0x22, 0x33, checked for all four CPOL/CPHA combinations.
REQ-039 The bench SHALL cover: cs rise after 5 bits of data frame 0xFF -> no wrStrobe and memory unchanged; the next transaction works normally.
REQ-040 The bench SHALL cover: resetN low for 1 clk mid-burst -> all outputs 0, LEDsOut=0, next read of addr 0 returns 0x00.
REQ-041 The bench SHALL cover: AUTO_INC=0, write cmd 0x85 with 0x01, 0x02 -> mem[5]=0x02 and two wrStrobes, both with wrAddr=5.
